// File: rtl/data_mem_port.sv
// MM-stage memory responder: turns MemRead/MemWrite into one req/ack bus access and stalls the pipeline until done.
// Optional MEM_TIMEOUT_EN aborts an unacknowledged access after TIMEOUT_CYCLES BUSY cycles and sets sticky bus_err.
module data_mem_port #(
   parameter int                ADDR_W         = 32,
   parameter int                DATA_W         = 32,
   parameter int                TIMEOUT_CYCLES = 16,
   parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEADBEEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              mem_stall,
   output logic [DATA_W-1:0] rdata,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              bus_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0] r_state;
   logic       w_req;
   logic       w_timeout;

   assign w_req     = MemRead | MemWrite;
   // DONE releases the stall for exactly one cycle so MM/WB can capture rdata
   assign mem_stall = ~rst & w_req & (r_state != S_DONE);

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic             w_unused_bits;

   assign w_timeout     = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign bus_err       = r_err;
   assign w_unused_bits = ^addr[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_state == S_BUSY && !bus_ack) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (r_state == S_BUSY && !bus_ack && w_timeout) begin
         r_err <= 1'b1;
      end
   end
`else
   logic w_unused_bits;

   assign w_timeout     = 1'b0;
   assign bus_err       = 1'b0;
   assign w_unused_bits = ^{addr[1:0], ERR_DATA, TIMEOUT_CYCLES[0]};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         rdata     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  bus_wdata <= wdata;
                  bus_we    <= MemWrite;
                  bus_req   <= 1'b1;
                  r_state   <= S_BUSY;
               end
            end
            S_BUSY: begin
               // the access completes even if the pipeline drops its request
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  if (!bus_we) begin
                     rdata <= bus_rdata;
                  end
                  r_state <= S_DONE;
               end else if (w_timeout) begin
                  bus_req <= 1'b0;
                  if (!bus_we) begin
                     rdata <= ERR_DATA;
                  end
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
